// File: rtl/list_prefetch.sv
// Lazy-list prefetcher: pulls elements from an upstream req/ack/eol producer into a small FIFO
// and re-serves them downstream with the same req/ack/eol protocol.
module list_prefetch #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_ready,
    output logic             o_src_req,
    input  logic             i_src_ack,
    input  logic             i_src_eol,
    input  logic [WIDTH-1:0] i_src_value,
    input  logic             i_req,
    output logic             o_ack,
    output logic             o_eol,
    output logic [WIDTH-1:0] o_value
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_push;
    logic             w_set_done;
    logic             w_edge;
    logic             w_empty;
    logic             w_pop;
    logic             w_set_pending;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_src_done;
    logic             r_pending;
    logic             r_last_req;
    logic             r_src_req;
    logic             r_ack;
    logic [WIDTH-1:0] r_value;

    // Fetch FSM next state: one element in flight at most, DROP forces a fresh src_req edge
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_src_eol) begin
                    w_set_done = 1'b1;
                end else if ((r_count < FULL) && !r_src_done) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_src_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else if (!i_ready) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Downstream side: a pending request is served as soon as the FIFO holds data
    assign w_edge        = i_req & ~r_last_req;
    assign w_empty       = (r_count == '0);
    assign w_pop         = !w_empty && (r_pending || w_edge);
    assign w_set_pending = w_edge && !r_pending && w_empty && !o_eol;

    assign o_eol     = r_src_done && w_empty && !r_pending && (r_state == S_IDLE);
    assign o_src_req = r_src_req;
    assign o_ack     = r_ack;
    assign o_value   = r_value;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_src_req  <= 1'b0;
            r_ack      <= 1'b0;
            r_value    <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_src_done <= 1'b0;
            r_pending  <= 1'b0;
            r_last_req <= 1'b0;
        end else if (!i_ready) begin
            r_src_req  <= 1'b0;
            r_ack      <= 1'b0;
            r_value    <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_src_done <= 1'b0;
            r_pending  <= 1'b0;
            r_last_req <= 1'b0;
        end else begin
            r_last_req <= i_req;
            r_src_req  <= (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT);
            r_ack      <= w_pop;
            if (w_set_done) begin
                r_src_done <= 1'b1;
            end
            if (w_pop) begin
                r_value  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_pending <= 1'b0;
            end else if (w_set_pending) begin
                r_pending <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge i_clock) begin
        if (w_push && i_ready) begin
            r_mem[r_wr_ptr] <= i_src_value;
        end
    end

endmodule

// File: tb/tb_list_prefetch.sv
// Directed bench for list_prefetch: upstream producer and downstream consumer driven from tasks,
// outputs sampled on the falling clock edge.
module tb_list_prefetch;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ready = 1'b1;
    logic       src_req;
    logic       src_ack = 1'b0;
    logic       src_eol = 1'b0;
    logic [7:0] src_value = 8'h00;
    logic       req = 1'b0;
    logic       ack;
    logic       eol;
    logic [7:0] value;

    int n_total = 0;
    int n_bad   = 0;
    int src_edges = 0;
    logic mon_prev = 1'b0;

    list_prefetch #(.WIDTH(8), .DEPTH(4)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_ready     (ready),
        .o_src_req   (src_req),
        .i_src_ack   (src_ack),
        .i_src_eol   (src_eol),
        .i_src_value (src_value),
        .i_req       (req),
        .o_ack       (ack),
        .o_eol       (eol),
        .o_value     (value)
    );

    always #5 clock = ~clock;

    // Count rising edges of src_req as seen between clock edges
    always @(negedge clock) begin
        if (src_req && !mon_prev) src_edges = src_edges + 1;
        mon_prev = src_req;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input logic eol_in);
        reset   = 1'b1;
        ready   = 1'b1;
        req     = 1'b0;
        src_ack = 1'b0;
        src_eol = eol_in;
        src_value = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Upstream producer: wait for src_req, answer lat cycles later with v
    task automatic serve(input logic [7:0] v, input int lat);
        int n = 0;
        while (!src_req && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("src_req_rise", 32'(src_req), 32'd1);
        repeat (lat) @(negedge clock);
        src_ack   = 1'b1;
        src_value = v;
        @(negedge clock);
        src_ack = 1'b0;
    endtask

    // Downstream consumer: one req edge, expect ack with v on the next cycle, then a single pulse
    task automatic pop_req(input string tag, input logic [7:0] v);
        req = 1'b1;
        @(negedge clock);
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_val"}, 32'(value), 32'(v));
        req = 1'b0;
        @(negedge clock);
        chk({tag, "_pulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        logic seen;

        // Reset state
        @(negedge clock);
        chk("rst_src_req", 32'(src_req), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_eol", 32'(eol), 32'd0);

        // bounded_enum 0,2,4,6 with no downstream demand: fills the FIFO, then stops fetching
        do_reset(1'b0);
        e0 = src_edges;
        serve(8'd0, 1);
        serve(8'd2, 1);
        serve(8'd4, 1);
        serve(8'd6, 1);
        src_eol = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (src_req) seen = 1'b1;
        end
        chk("full_edges", 32'(src_edges - e0), 32'd4);
        chk("full_src_req_low", 32'(seen), 32'd0);
        chk("full_eol", 32'(eol), 32'd0);
        pop_req("enum0", 8'd0);
        pop_req("enum1", 8'd2);
        pop_req("enum2", 8'd4);
        chk("eol_before_last", 32'(eol), 32'd0);
        pop_req("enum3", 8'd6);
        chk("eol_after_last", 32'(eol), 32'd1);

        // Request while empty; upstream answers 3 cycles after the req edge
        do_reset(1'b0);
        req = 1'b1;
        @(negedge clock);
        chk("pend_src_req", 32'(src_req), 32'd1);
        chk("pend_no_ack", 32'(ack), 32'd0);
        @(negedge clock);
        @(negedge clock);
        src_ack   = 1'b1;
        src_value = 8'h15;
        @(negedge clock);
        src_ack = 1'b0;
        chk("pend_push_cycle_ack", 32'(ack), 32'd0);
        @(negedge clock);
        chk("pend_ack", 32'(ack), 32'd1);
        chk("pend_val", 32'(value), 32'h15);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (ack) seen = 1'b1;
        end
        chk("pend_no_dup", 32'(seen), 32'd0);
        req = 1'b0;

        // Pop coinciding with push at count=1
        do_reset(1'b0);
        serve(8'h11, 1);
        begin
            int n = 0;
            while (!src_req && n < 50) begin
                @(negedge clock);
                n++;
            end
        end
        chk("sim_src_req", 32'(src_req), 32'd1);
        @(negedge clock);
        src_ack   = 1'b1;
        src_value = 8'h22;
        req       = 1'b1;
        @(negedge clock);
        src_ack = 1'b0;
        req     = 1'b0;
        chk("sim_ack", 32'(ack), 32'd1);
        chk("sim_old_head", 32'(value), 32'h11);
        @(negedge clock);
        chk("sim_pulse", 32'(ack), 32'd0);
        pop_req("sim_next", 8'h22);

        // ready dropped during WAIT abandons the fetch; restart refetches from the first element
        do_reset(1'b0);
        begin
            int n = 0;
            while (!src_req && n < 50) begin
                @(negedge clock);
                n++;
            end
        end
        @(negedge clock);
        ready     = 1'b0;
        src_ack   = 1'b1;
        src_value = 8'h30;
        @(negedge clock);
        chk("flush_src_req", 32'(src_req), 32'd0);
        chk("flush_ack", 32'(ack), 32'd0);
        chk("flush_eol", 32'(eol), 32'd0);
        ready   = 1'b1;
        src_ack = 1'b0;
        serve(8'h30, 1);
        serve(8'h32, 1);
        pop_req("restart0", 8'h30);
        pop_req("restart1", 8'h32);

        // Asynchronous reset between clock edges
        serve(8'h44, 1);
        req = 1'b1;
        @(negedge clock);
        chk("pre_rst_ack", 32'(ack), 32'd1);
        chk("pre_rst_val", 32'(value), 32'h44);
        #1 reset = 1'b1;
        #1;
        chk("async_src_req", 32'(src_req), 32'd0);
        chk("async_ack", 32'(ack), 32'd0);
        chk("async_value", 32'(value), 32'd0);
        req = 1'b0;

        // Empty list: eol from the start, no fetch, req edge ignored
        do_reset(1'b1);
        e0 = src_edges;
        @(negedge clock);
        @(negedge clock);
        chk("empty_eol", 32'(eol), 32'd1);
        req = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (ack) seen = 1'b1;
        end
        chk("empty_no_ack", 32'(seen), 32'd0);
        chk("empty_value", 32'(value), 32'd0);
        chk("empty_no_src_req", 32'(src_edges - e0), 32'd0);
        req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
